// File: rtl/rf_access_ctrl.sv
// Command sequencer in front of an 8x32 register file: accepts READ/WRITE/COPY/CLEAR
// over a valid/ready request channel and returns one response per command.
module rf_access_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData,
  output logic              busy
);

  localparam int         NUM_REGS = 2 ** ADDR_W;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    CP   = 3'd3,
    CLR  = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t              r_state;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_addr2;
  logic [ADDR_W-1:0]   r_raddr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [1:0]          r_rsp_op;
  logic [DATA_W-1:0]   r_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= 2'b00;
      r_addr      <= '0;
      r_addr2     <= '0;
      r_raddr     <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= 2'b00;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_op        <= req_op;
            r_addr      <= req_addr;
            r_addr2     <= req_addr2;
            r_wdata     <= req_wdata;
            // The read address only moves for commands that read, otherwise it holds.
            if (req_op == OP_READ || req_op == OP_COPY)
              r_raddr <= req_addr;
            case (req_op)
              OP_READ:  r_state <= RD;
              OP_WRITE: r_state <= WR;
              OP_COPY:  r_state <= CP;
              OP_CLEAR: r_state <= CLR;
              default:  r_state <= IDLE;
            endcase
          end
        end
        RD, CP: begin
          r_rsp_data  <= rf_rData;
          r_rsp_op    <= r_op;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        WR: begin
          r_rsp_data  <= r_wdata;
          r_rsp_op    <= r_op;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        CLR: begin
          if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
            r_cnt       <= '0;
            r_rsp_data  <= CLEAR_VAL;
            r_rsp_op    <= r_op;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Write port is a pure decode of state and latched operands; COPY forwards read data.
  always_comb begin
    rf_we    = 1'b0;
    rf_wAddr = '0;
    rf_wData = '0;
    case (r_state)
      WR: begin
        rf_we    = 1'b1;
        rf_wAddr = r_addr;
        rf_wData = r_wdata;
      end
      CP: begin
        rf_we    = 1'b1;
        rf_wAddr = r_addr2;
        rf_wData = rf_rData;
      end
      CLR: begin
        rf_we    = 1'b1;
        rf_wAddr = r_cnt;
        rf_wData = CLEAR_VAL;
      end
      default: begin
        rf_we    = 1'b0;
        rf_wAddr = '0;
        rf_wData = '0;
      end
    endcase
  end

  assign rf_rAddr  = r_raddr;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_op    = r_rsp_op;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 8x32 register file attached
// to its write/read ports; every expected value below is hand-derived.
module tb_rf_access_ctrl;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CP = 2'b10;
  localparam logic [1:0] OP_CL = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [2:0]  req_addr = 3'd0;
  logic [2:0]  req_addr2 = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_data;
  logic [2:0]  rf_wAddr;
  logic [31:0] rf_wData;
  logic        rf_we;
  logic [2:0]  rf_rAddr;
  logic [31:0] rf_rData;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  rf_access_ctrl #(.DATA_W(32), .ADDR_W(3), .CLEAR_VAL(32'd0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_addr2(req_addr2), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .rf_wAddr(rf_wAddr), .rf_wData(rf_wData), .rf_we(rf_we),
    .rf_rAddr(rf_rAddr), .rf_rData(rf_rData), .busy(busy)
  );

  // Register file model: not touched by reset, combinational read.
  logic [31:0] rf_mem [8];
  always @(posedge clk) if (rf_we) rf_mem[rf_wAddr] <= rf_wData;
  assign rf_rData = rf_mem[rf_rAddr];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [2:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         wq[$];
  int          acc_q[$];
  logic [33:0] rsp_q[$];

  always @(negedge clk) begin
    if (rf_we) wq.push_back('{c: cyc, a: rf_wAddr, d: rf_wData});
    if (req_valid && req_ready) acc_q.push_back(cyc);
    if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_op, rsp_data});
  end

  // Issues one command with rsp_ready high; lat is the number of edges after the
  // accepting edge until rsp_valid is seen (-1 on timeout).
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] a2,
                         input logic [31:0] wd, output logic [1:0] rop,
                         output logic [31:0] rdata, output int lat);
    int n;
    rsp_ready = 1'b1;
    req_op = op; req_addr = a; req_addr2 = a2; req_wdata = wd;
    req_valid = 1'b1;
    rop = 2'b00; rdata = 32'd0; lat = -1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) return;
    lat = n;
    rop = rsp_op;
    rdata = rsp_data;
    @(posedge clk); #1;
    $display("cmd op=%0d addr=%0d addr2=%0d wdata=%h -> rsp_op=%0d rsp_data=%h lat=%0d",
             op, a, a2, wd, rop, rdata, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_op, rsp_data, rf_we, rf_wAddr, rf_wData, rf_rAddr, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {req_ready, rsp_valid, rsp_op, rsp_data, rf_we, rf_wAddr, rf_wData, rf_rAddr, busy});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: req_ready,busy=%b required 10", {req_ready, busy});
    end
  endtask

  task automatic test_write_read;
    logic [1:0] rop; logic [31:0] rd; int lat;
    wq.delete();
    run_cmd(OP_WR, 3'd5, 3'd0, 32'hDEADBEEF, rop, rd, lat);
    checks++;
    if ({lat, rop, rd} !== {32'sd1, OP_WR, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL write_rsp: lat=%0d op=%0d data=%h required lat=1 op=1 data=deadbeef", lat, rop, rd);
    end
    checks++;
    if (wq.size() !== 1) begin
      failures++;
      $display("FAIL write_we_cycles: got %0d required 1", wq.size());
    end else begin
      checks++;
      if ({wq[0].a, wq[0].d} !== {3'd5, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL write_port: addr=%0d data=%h required addr=5 data=deadbeef", wq[0].a, wq[0].d);
      end
    end
    wq.delete();
    run_cmd(OP_RD, 3'd5, 3'd0, 32'd0, rop, rd, lat);
    checks++;
    if ({lat, rop, rd} !== {32'sd1, OP_RD, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL read_rsp: lat=%0d op=%0d data=%h required lat=1 op=0 data=deadbeef", lat, rop, rd);
    end
    checks++;
    if (wq.size() !== 0) begin
      failures++;
      $display("FAIL read_no_write: got %0d writes required 0", wq.size());
    end
  endtask

  task automatic test_copy;
    logic [1:0] rop; logic [31:0] rd; int lat;
    run_cmd(OP_WR, 3'd2, 3'd0, 32'h12345678, rop, rd, lat);
    run_cmd(OP_WR, 3'd3, 3'd0, 32'h33333333, rop, rd, lat);
    wq.delete();
    run_cmd(OP_CP, 3'd2, 3'd7, 32'hFFFFFFFF, rop, rd, lat);
    checks++;
    if ({lat, rop, rd} !== {32'sd1, OP_CP, 32'h12345678}) begin
      failures++;
      $display("FAIL copy_rsp: lat=%0d op=%0d data=%h required lat=1 op=2 data=12345678", lat, rop, rd);
    end
    checks++;
    if (wq.size() !== 1 || wq[0].a !== 3'd7 || wq[0].d !== 32'h12345678) begin
      failures++;
      $display("FAIL copy_port: writes=%0d required one write of 12345678 to r7", wq.size());
    end
    run_cmd(OP_RD, 3'd7, 3'd0, 32'd0, rop, rd, lat);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++;
      $display("FAIL copy_read_dst: got %h required 12345678", rd);
    end
    run_cmd(OP_RD, 3'd2, 3'd0, 32'd0, rop, rd, lat);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++;
      $display("FAIL copy_src_kept: got %h required 12345678", rd);
    end
    run_cmd(OP_CP, 3'd3, 3'd3, 32'd0, rop, rd, lat);
    checks++;
    if (rd !== 32'h33333333 || rf_mem[3] !== 32'h33333333) begin
      failures++;
      $display("FAIL copy_self: rsp=%h r3=%h required 33333333", rd, rf_mem[3]);
    end
  endtask

  task automatic test_clear;
    logic [1:0] rop; logic [31:0] rd; int lat;
    for (int i = 0; i < 8; i++) run_cmd(OP_WR, 3'(i), 3'd0, 32'h100 + i, rop, rd, lat);
    wq.delete();
    run_cmd(OP_CL, 3'd0, 3'd0, 32'hFFFFFFFF, rop, rd, lat);
    checks++;
    if ({lat, rop, rd} !== {32'sd8, OP_CL, 32'd0}) begin
      failures++;
      $display("FAIL clear_rsp: lat=%0d op=%0d data=%h required lat=8 op=3 data=0", lat, rop, rd);
    end
    checks++;
    if (wq.size() !== 8) begin
      failures++;
      $display("FAIL clear_we_cycles: got %0d required 8", wq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wq[i].a !== 3'(i) || wq[i].d !== 32'd0 || wq[i].c !== wq[0].c + i) begin
          failures++;
          $display("FAIL clear_write_%0d: addr=%0d data=%h cyc_off=%0d required addr=%0d data=0 cyc_off=%0d",
                   i, wq[i].a, wq[i].d, wq[i].c - wq[0].c, i, i);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      run_cmd(OP_RD, 3'(i), 3'd0, 32'd0, rop, rd, lat);
      checks++;
      if (rd !== 32'd0) begin
        failures++;
        $display("FAIL clear_read_r%0d: got %h required 0", i, rd);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] rop; logic [31:0] rd; int lat;
    run_cmd(OP_WR, 3'd4, 3'd0, 32'hCAFE0004, rop, rd, lat);
    wq.delete();
    rsp_ready = 1'b0;
    req_op = OP_RD; req_addr = 3'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    // Second command presented and held while the first is outstanding.
    req_op = OP_WR; req_addr = 3'd6; req_wdata = 32'h00000066;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({rsp_valid, rsp_op, rsp_data, req_ready, busy} !== {1'b1, OP_RD, 32'hCAFE0004, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL bp_hold_%0d: valid=%b op=%0d data=%h ready=%b busy=%b required 1 0 cafe0004 0 1",
                 k, rsp_valid, rsp_op, rsp_data, req_ready, busy);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (wq.size() !== 0) begin
      failures++;
      $display("FAIL bp_no_write: got %0d writes required 0", wq.size());
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL bp_idle: valid,ready,busy=%b required 010", {rsp_valid, req_ready, busy});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({busy, rf_we, rf_wAddr, rf_wData} !== {1'b1, 1'b1, 3'd6, 32'h00000066}) begin
      failures++;
      $display("FAIL bp_second_accept: busy=%b we=%b addr=%0d data=%h required 1 1 6 00000066",
               busy, rf_we, rf_wAddr, rf_wData);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_op, rsp_data} !== {1'b1, OP_WR, 32'h00000066}) begin
      failures++;
      $display("FAIL bp_second_rsp: valid=%b op=%0d data=%h required 1 1 00000066", rsp_valid, rsp_op, rsp_data);
    end
    @(posedge clk); #1;
    $display("backpressure sequence done");
  endtask

  task automatic test_reset_mid_clear;
    logic [1:0] rop; logic [31:0] rd; int lat;
    for (int i = 0; i < 8; i++)
      run_cmd(OP_WR, 3'(i), 3'd0, (i < 3) ? 32'h55 : 32'hAA, rop, rd, lat);
    wq.delete();
    req_op = OP_CL; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_op, rsp_data, rf_we, rf_wAddr, rf_wData, rf_rAddr, busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h required 0",
               {req_ready, rsp_valid, rsp_op, rsp_data, rf_we, rf_wAddr, rf_wData, rf_rAddr, busy});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || wq.size() !== 3) begin
      failures++;
      $display("FAIL midreset_aborted: rsp_valid=%b writes=%0d required 0 and 3", rsp_valid, wq.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_mem[i] !== ((i < 3) ? 32'h0 : 32'hAA)) begin
        failures++;
        $display("FAIL midreset_r%0d: got %h required %h", i, rf_mem[i], (i < 3) ? 32'h0 : 32'hAA);
      end
    end
    run_cmd(OP_RD, 3'd5, 3'd0, 32'd0, rop, rd, lat);
    checks++;
    if ({lat, rop, rd} !== {32'sd1, OP_RD, 32'hAA}) begin
      failures++;
      $display("FAIL midreset_read: lat=%0d op=%0d data=%h required 1 0 000000aa", lat, rop, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sop [8];
    logic [2:0]  sa  [8];
    logic [31:0] sd  [8];
    logic [31:0] exp_d;
    logic        was;
    int          idx;
    for (int i = 0; i < 4; i++) begin
      sop[i] = OP_WR; sa[i] = 3'(2 * i + 1); sd[i] = 32'h50000000 + 32'(i * 32'h111);
      sop[i + 4] = OP_RD; sa[i + 4] = sa[i]; sd[i + 4] = 32'd0;
    end
    acc_q.delete(); rsp_q.delete();
    rsp_ready = 1'b1;
    idx = 0;
    req_op = sop[0]; req_addr = sa[0]; req_wdata = sd[0]; req_valid = 1'b1;
    for (int n = 0; n < 100 && idx < 8; n++) begin
      was = req_ready;
      @(posedge clk); #1;
      if (was) begin
        idx++;
        if (idx < 8) begin
          req_op = sop[idx]; req_addr = sa[idx]; req_wdata = sd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    for (int n = 0; n < 20 && rsp_q.size() < 8; n++) begin @(posedge clk); #1; end
    checks++;
    if (acc_q.size() !== 8 || rsp_q.size() !== 8) begin
      failures++;
      $display("FAIL stream_counts: accepted=%0d responses=%0d required 8 and 8", acc_q.size(), rsp_q.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (acc_q[i] - acc_q[i - 1] !== 3) begin
          failures++;
          $display("FAIL stream_interval_%0d: got %0d required 3", i, acc_q[i] - acc_q[i - 1]);
        end
      end
      for (int i = 0; i < 8; i++) begin
        exp_d = sd[i % 4];
        $display("stream rsp %0d: op=%0d data=%h", i, rsp_q[i][33:32], rsp_q[i][31:0]);
        checks++;
        if (rsp_q[i] !== {sop[i], exp_d}) begin
          failures++;
          $display("FAIL stream_rsp_%0d: got %h required %h", i, rsp_q[i], {sop[i], exp_d});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_copy();
    test_clear();
    test_backpressure();
    test_reset_mid_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
